sha256_msg_schedule: RTL and testbench
======================================

Name: sha256_msg_schedule

Overview:
- Message-schedule expander that sits directly upstream of the SHA-256 round stage.
- Accepts one 512-bit padded message block, then streams W[0..63] one word per handshake on its `w_out` port, which feeds the round stage's `w` input.
- Uses a 16-word shift window, so only one new schedule word is computed per accepted output.
- A round controller downstream pairs each word with K[t] by using `w_idx`.

Parameters:
- NUM_ROUNDS, 64, number of W words emitted per block. Legal range is 17..64; the default is the only value used in production.

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- rst  input  1  reset, asynchronous and active-high
- blk_valid  input  1  `blk_data` holds a padded block
- blk_ready  output  1  block can be accepted
- blk_data  input  512  block; word 0 = bits [511:480], word 15 = bits [31:0], big-endian per FIPS 180-4
- flush  input  1  synchronous abort of the current block
- w_valid  output  1  `w_out` holds W[t]
- w_ready  input  1  downstream consumes W[t]
- w_out  output  32  schedule word W[t]
- w_idx  output  6  current t, 0..NUM_ROUNDS-1
- w_last  output  1  high when w_valid=1 and t=NUM_ROUNDS-1
- busy  output  1  high in RUN

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, window all 0, t=0.
  - Output values in reset: blk_ready=1, w_valid=0, w_out=0, w_idx=0, w_last=0, busy=0.
- States:
  - IDLE: blk_ready=1, w_valid=0.
  - RUN: blk_ready=0 (unless the optional feature is enabled), w_valid=1.
- IDLE->RUN: when blk_valid&&blk_ready.
  - Load window[i] = word i of `blk_data`, set t=0.
  - W[0] is presented on the next cycle, so latency from block accept to w_valid is 1 cycle.
- Output values: `w_out` = window[0], `w_idx` = t. Both are registered, with no combinational path from inputs.
- On a w_valid&&w_ready handshake in RUN:
  - Shift window[i] <= window[i+1] for i=0..14.
  - window[15] <= s1(window[14]) + window[9] + s0(window[1]) + window[0], with 32-bit modulo addition. This yields W[t+16].
  - s0(x) = ROTR7 ^ ROTR18 ^ SHR3.
  - s1(x) = ROTR17 ^ ROTR19 ^ SHR10.
  - t <= t+1.
  - Words computed for t+16 >= NUM_ROUNDS are never emitted. Computing them is allowed; no gating is required.
- Stall: with w_ready=0 and w_valid=1, `w_out`, `w_idx` and `w_last` hold stable. The window does not shift.
- End of block: a handshake at t=NUM_ROUNDS-1 moves RUN->IDLE and sets t=0. blk_ready is high from the next cycle.
- flush=1:
  - Any state goes to IDLE next cycle: w_valid=0, t=0; window contents are don't-care.
  - flush has priority over both the block handshake and the W handshake in the same cycle.
  - A block offered in the flush cycle is not accepted; blk_ready=0 that cycle.
- Asynchronous reset during RUN: immediate return to the reset values; no partial word is emitted.
- blk_valid while in RUN: ignored; the source holds `blk_data` until blk_ready.
- Steady-state throughput: 64 words per 65 cycles.

Optional Feature:
- Macro: SHA256_SCHED_PRELOAD_EN.
- Enabled:
  - blk_ready is also high in RUN when w_last&&w_ready.
  - A block handshake in that same cycle loads the window, sets t=0 and stays in RUN.
  - W[0] of the new block follows W[63] of the old block with no bubble, giving 64 words per 64 cycles.
  - blk_ready then has a combinational path from w_ready.
- Disabled: blk_ready is high only in IDLE, which is the one-cycle bubble described above.

Decomposition:
- sha256_pkg holds:
  - functions s0 and s1 (small sigma);
  - localparams WORD_W=32, BLK_WORDS=16, BLK_W=512;
  - an enum for the IDLE/RUN state.
- One sub-module, sha256_sched_word: a combinational W[t+16] generator with four 32-bit inputs (w_m16, w_m15, w_m7, w_m2) and one output. It is reusable by a future fully unrolled schedule.

Test Plan:
- "abc" padded block: W0=0x61626380, W1..W14=0, W15=0x00000018, w_ready=1.
  - Expect W16=0x61626380 and W17=0x000F0000.
  - Expect w_idx to step 0..63, w_last only at 63, and all 64 words matching the C reference model.
- Random backpressure (w_ready 50% random) on random blocks: the word sequence is identical to the no-stall run, and `w_out` is stable during every stall.
- flush asserted at t=20, with w_ready=1 and blk_valid=1 in the same cycle:
  - next cycle w_valid=0 and state is IDLE;
  - the block is not accepted; the next block starts at w_idx=0.
- Asynchronous reset pulse mid-cycle at t=37: outputs go to reset values immediately, and after release blk_ready=1 and w_valid=0.
- Back-to-back blocks with blk_valid held high:
  - without SHA256_SCHED_PRELOAD_EN: exactly one w_valid=0 cycle between W63 and the next W0;
  - with it: zero gap cycles, and the second block's words are correct.
- blk_valid pulsed during RUN: no effect on the word stream; blk_ready stays 0 until the block ends.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared types, widths and small-sigma helpers for the SHA-256 message schedule.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sha256_pkg;

    localparam int WORD_W    = 32;
    localparam int BLK_WORDS = 16;
    localparam int BLK_W     = 512;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } sched_state_t;

    // sigma0: ROTR7 ^ ROTR18 ^ SHR3
    function automatic logic [WORD_W-1:0] s0(input logic [WORD_W-1:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    // sigma1: ROTR17 ^ ROTR19 ^ SHR10
    function automatic logic [WORD_W-1:0] s1(input logic [WORD_W-1:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_msg_schedule_if.sv
// Block-in / word-out bus of the SHA-256 message schedule expander.
// Latency: n/a (signal bundle only).
// Backpressure: valid/ready on both the block side and the word side.
interface sha256_msg_schedule_if;
    import sha256_pkg::*;

    logic                 blk_valid;
    logic                 blk_ready;
    logic [BLK_W-1:0]     blk_data;
    logic                 flush;
    logic                 w_valid;
    logic                 w_ready;
    logic [WORD_W-1:0]    w_out;
    logic [5:0]           w_idx;
    logic                 w_last;
    logic                 busy;

    // Schedule expander side.
    modport slave (
        input  blk_valid, blk_data, flush, w_ready,
        output blk_ready, w_valid, w_out, w_idx, w_last, busy
    );

    // Block source / round-stage side.
    modport master (
        output blk_valid, blk_data, flush, w_ready,
        input  blk_ready, w_valid, w_out, w_idx, w_last, busy
    );

endinterface

// File: rtl/sha256_sched_word.sv
// Combinational W[t+16] generator: s1(W[t+14]) + W[t+9] + s0(W[t+1]) + W[t].
// Latency: 0 cycles (pure combinational).
// Backpressure: none; caller decides when to capture the result.
module sha256_sched_word
    import sha256_pkg::*;
(
    input  logic [WORD_W-1:0] w_m16,
    input  logic [WORD_W-1:0] w_m15,
    input  logic [WORD_W-1:0] w_m7,
    input  logic [WORD_W-1:0] w_m2,
    output logic [WORD_W-1:0] w_new
);

    // Modulo-2^32 sum of the four schedule terms.
    always_comb begin
        w_new = s1(w_m2) + w_m7 + s0(w_m15) + w_m16;
    end

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads a 512-bit block, streams W[0..NUM_ROUNDS-1] via a 16-word window.
// Latency: W[0] valid 1 cycle after block accept; one word per w handshake, flush/idle gap of 1 cycle.
// Backpressure: w_ready=0 freezes window and outputs; SHA256_SCHED_PRELOAD_EN lets the next block load on the last word.
module sha256_msg_schedule
    import sha256_pkg::*;
#(
    parameter int NUM_ROUNDS = 64   // legal 17..64
)
(
    input  logic                 clk,
    input  logic                 rst,
    sha256_msg_schedule_if.slave bus
);

    localparam logic [5:0] LAST_T = 6'(NUM_ROUNDS - 1);

    sched_state_t                          state_q, state_d;
    logic [5:0]                            t_q, t_d;
    logic [BLK_WORDS-1:0][WORD_W-1:0]      win_q, win_d;
    logic [WORD_W-1:0]                     w_new;
    logic                                  at_last;
    logic                                  w_hs;
    logic                                  blk_hs;

    // Window taps: W[t], W[t+1], W[t+9], W[t+14] produce W[t+16].
    sha256_sched_word u_word (
        .w_m16 (win_q[0]),
        .w_m15 (win_q[1]),
        .w_m7  (win_q[9]),
        .w_m2  (win_q[14]),
        .w_new (w_new)
    );

    assign at_last = (state_q == ST_RUN) && (t_q == LAST_T);

`ifdef SHA256_SCHED_PRELOAD_EN
    // Next block may land on the same edge as the last word leaves.
    assign bus.blk_ready = !bus.flush && ((state_q == ST_IDLE) || (at_last && bus.w_ready));
`else
    assign bus.blk_ready = !bus.flush && (state_q == ST_IDLE);
`endif

    assign blk_hs      = bus.blk_valid && bus.blk_ready;
    assign w_hs        = (state_q == ST_RUN) && bus.w_ready && !bus.flush;

    assign bus.w_valid = (state_q == ST_RUN);
    assign bus.busy    = (state_q == ST_RUN);
    assign bus.w_out   = win_q[0];
    assign bus.w_idx   = t_q;
    assign bus.w_last  = at_last;

    // Next state: flush wins, then block load overrides the word shift.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        win_d   = win_q;
        if (bus.flush) begin
            state_d = ST_IDLE;
            t_d     = '0;
        end else begin
            if (w_hs) begin
                for (int i = 0; i < BLK_WORDS - 1; i++) begin
                    win_d[i] = win_q[i+1];
                end
                win_d[BLK_WORDS-1] = w_new;
                if (t_q == LAST_T) begin
                    state_d = ST_IDLE;
                    t_d     = '0;
                end else begin
                    t_d = t_q + 6'd1;
                end
            end
            if (blk_hs) begin
                for (int i = 0; i < BLK_WORDS; i++) begin
                    win_d[i] = bus.blk_data[BLK_W-1-WORD_W*i -: WORD_W];
                end
                state_d = ST_RUN;
                t_d     = '0;
            end
        end
    end

    // State, round counter and window registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            t_q     <= '0;
            win_q   <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            win_q   <= win_d;
        end
    end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
module tb_sha256_msg_schedule;

    localparam int NR = 64;
`ifdef SHA256_SCHED_PRELOAD_EN
    localparam bit PRELOAD = 1'b1;
`else
    localparam bit PRELOAD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sha256_msg_schedule_if bus();

    sha256_msg_schedule #(.NUM_ROUNDS(NR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_w [64];

    function automatic logic [31:0] ss0(input logic [31:0] x);
        return ((x >> 7) | (x << 25)) ^ ((x >> 18) | (x << 14)) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ss1(input logic [31:0] x);
        return ((x >> 17) | (x << 15)) ^ ((x >> 19) | (x << 13)) ^ (x >> 10);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference schedule in the textbook array form.
    task automatic fill_exp(input logic [511:0] blk);
        for (int i = 0; i < 16; i++) exp_w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 64; i++)
            exp_w[i] = ss1(exp_w[i-2]) + exp_w[i-7] + ss0(exp_w[i-15]) + exp_w[i-16];
    endtask

    task automatic rand_blk(output logic [511:0] blk);
        for (int i = 0; i < 16; i++) blk[i*32 +: 32] = $urandom;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_blk_ready"}, 32'(bus.blk_ready), 32'd1);
        chk({tag, "_w_valid"},   32'(bus.w_valid),   32'd0);
        chk({tag, "_w_out"},     bus.w_out,          32'd0);
        chk({tag, "_w_idx"},     32'(bus.w_idx),     32'd0);
        chk({tag, "_w_last"},    32'(bus.w_last),    32'd0);
        chk({tag, "_busy"},      32'(bus.busy),      32'd0);
    endtask

    // Offer a block and wait for acceptance; returns at posedge+1 after the accept edge.
    task automatic accept(input logic [511:0] blk);
        int k;
        fill_exp(blk);
        bus.blk_data  = blk;
        bus.blk_valid = 1'b1;
        bus.flush     = 1'b0;
        bus.w_ready   = 1'b0;
        k = 0;
        #1;
        while (!bus.blk_ready && k < 40) begin
            @(posedge clk); #2;
            k++;
        end
        chk("blk_accept", 32'(bus.blk_ready), 32'd1);
        @(posedge clk); #1;
        bus.blk_valid = 1'b0;
        chk("latency_w_valid", 32'(bus.w_valid), 32'd1);
        chk("latency_w_idx",   32'(bus.w_idx),   32'd0);
    endtask

    // vmode: 0 leave blk_valid alone, 1 random pulses (low on last word).
    task automatic stream(input int stop_at, input bit bp, input int vmode, input bit abc);
        int t;
        int cyc;
        bit stalled;
        logic [31:0] held;
        t = 0; cyc = 0; stalled = 0; held = '0;
        while (t < stop_at && cyc < 2000) begin
            chk("w_valid", 32'(bus.w_valid), 32'd1);
            chk("busy",    32'(bus.busy),    32'd1);
            chk("w_idx",   32'(bus.w_idx),   32'(t));
            chk("w_out",   bus.w_out,        exp_w[t]);
            chk("w_last",  32'(bus.w_last),  32'(t == NR-1));
            if (stalled) chk("stall_hold", bus.w_out, held);
            if (abc && t == 16) chk("abc_w16", bus.w_out, 32'h61626380);
            if (abc && t == 17) chk("abc_w17", bus.w_out, 32'h000F0000);
            bus.w_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (vmode == 1) bus.blk_valid = (t == NR-1) ? 1'b0 : 1'($urandom_range(0, 1));
            #1;
            chk("blk_ready_run", 32'(bus.blk_ready), 32'(PRELOAD && t == NR-1 && bus.w_ready));
            if (bus.w_ready) begin
                stalled = 0;
                t++;
            end else begin
                stalled = 1;
                held = bus.w_out;
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (t < stop_at) chk("stream_timeout", 32'(t), 32'(stop_at));
    endtask

    task automatic end_checks(input string tag);
        bus.w_ready   = 1'b0;
        bus.blk_valid = 1'b0;
        #1;
        chk({tag, "_end_w_valid"},   32'(bus.w_valid),   32'd0);
        chk({tag, "_end_busy"},      32'(bus.busy),      32'd0);
        chk({tag, "_end_blk_ready"}, 32'(bus.blk_ready), 32'd1);
    endtask

    task automatic run_block(input logic [511:0] blk, input bit bp, input int vmode, input bit abc);
        accept(blk);
        stream(NR, bp, vmode, abc);
        end_checks("blk");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] blk_a;
        logic [511:0] blk_b;
        int gap;

        rst = 1'b1;
        bus.blk_valid = 1'b0;
        bus.blk_data  = '0;
        bus.flush     = 1'b0;
        bus.w_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        #2 rst = 1'b0;
        @(posedge clk); #1;
        chk_reset_vals("post_reset");

        // "abc" padded block, no stalls
        blk_a = '0;
        blk_a[511:480] = 32'h61626380;
        blk_a[31:0]    = 32'h00000018;
        run_block(blk_a, 1'b0, 0, 1'b1);

        // random blocks under random backpressure
        for (int n = 0; n < 2; n++) begin
            rand_blk(blk_a);
            run_block(blk_a, 1'b1, 0, 1'b0);
        end

        // flush at t=20 with w_ready and a competing block offer
        rand_blk(blk_a);
        rand_blk(blk_b);
        accept(blk_a);
        stream(20, 1'b0, 0, 1'b0);
        chk("flush_pre_idx", 32'(bus.w_idx), 32'd20);
        bus.flush     = 1'b1;
        bus.w_ready   = 1'b1;
        bus.blk_valid = 1'b1;
        bus.blk_data  = blk_b;
        #1;
        chk("flush_blk_ready", 32'(bus.blk_ready), 32'd0);
        @(posedge clk); #1;
        chk("flush_w_valid", 32'(bus.w_valid), 32'd0);
        chk("flush_busy",    32'(bus.busy),    32'd0);
        chk("flush_w_idx",   32'(bus.w_idx),   32'd0);
        bus.flush     = 1'b0;
        bus.blk_valid = 1'b0;
        run_block(blk_b, 1'b0, 0, 1'b0);

        // asynchronous reset mid-cycle at t=37
        rand_blk(blk_a);
        accept(blk_a);
        stream(37, 1'b1, 0, 1'b0);
        chk("arst_pre_idx", 32'(bus.w_idx), 32'd37);
        bus.w_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk_reset_vals("arst");
        #2 rst = 1'b0;
        @(posedge clk); #1;
        chk("arst_rel_blk_ready", 32'(bus.blk_ready), 32'd1);
        chk("arst_rel_w_valid",   32'(bus.w_valid),   32'd0);

        // back-to-back blocks with blk_valid held high
        rand_blk(blk_a);
        rand_blk(blk_b);
        accept(blk_a);
        bus.blk_data  = blk_b;
        bus.blk_valid = 1'b1;
        stream(NR, 1'b0, 0, 1'b0);
        fill_exp(blk_b);
        bus.w_ready = 1'b0;
        gap = 0;
        while (!bus.w_valid && gap < 5) begin
            @(posedge clk); #1;
            gap++;
        end
        chk("b2b_gap", 32'(gap), PRELOAD ? 32'd0 : 32'd1);
        bus.blk_valid = 1'b0;
        stream(NR, 1'b0, 0, 1'b0);
        end_checks("b2b");

        // blk_valid pulsed during RUN has no effect
        rand_blk(blk_a);
        run_block(blk_a, 1'b1, 1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
